// File: rtl/step_pulse_generator.sv
// Step/direction pulse generator: pops motion records from a FIFO and plays them out on 4 motor channels.
// Build option STEP_GEN_UNDERRUN_COUNT_EN adds an 8-bit saturating FIFO-starvation counter output.
module step_pulse_generator #(
  parameter int STEP_PERIOD = 1000,
  parameter int PULSE_WIDTH = 100,
  parameter int DIR_SETUP   = 50
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        fifo_empty,
  input  logic [15:0] fifo_data,
  output logic        fifo_read_en,
  output logic [3:0]  step_out,
  output logic [3:0]  dir_out,
  output logic        busy,
  output logic        segment_done
`ifdef STEP_GEN_UNDERRUN_COUNT_EN
  ,
  output logic [7:0]  underrun_count
`endif
);

  localparam int TMAX = (STEP_PERIOD > DIR_SETUP) ? STEP_PERIOD : DIR_SETUP;
  localparam int TW   = $clog2(TMAX + 1);

  // Timers count down to zero, so each reload is the phase length minus one.
  localparam logic [TW-1:0] SETUP_LD = TW'(DIR_SETUP - 1);
  localparam logic [TW-1:0] HIGH_LD  = TW'(PULSE_WIDTH - 1);
  localparam logic [TW-1:0] LOW_LD   = TW'(STEP_PERIOD - PULSE_WIDTH - 1);
  localparam logic [TW-1:0] DWELL_LD = TW'(STEP_PERIOD - 1);

  typedef enum logic [2:0] {IDLE, LATCH, SETUP, HIGH, LOW} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [3:0]      mask_q, mask_d;
  logic [3:0]      dir_q, dir_d;
  logic [7:0]      count_q, count_d;
  logic            seg_done_q, seg_done_d;

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    mask_d       = mask_q;
    dir_d        = dir_q;
    count_d      = count_q;
    seg_done_d   = 1'b0;
    fifo_read_en = 1'b0;
    case (state_q)
      IDLE: begin
        fifo_read_en = enable & ~fifo_empty & ~reset;
        if (fifo_read_en) state_d = LATCH;
      end
      LATCH: begin
        mask_d  = fifo_data[3:0];
        dir_d   = fifo_data[7:4];
        count_d = fifo_data[15:8];
        timer_d = SETUP_LD;
        state_d = SETUP;
      end
      SETUP: begin
        if (timer_q == '0) begin
          // A zero count is a pure dwell: one silent step period.
          if (count_q != 8'd0) begin
            state_d = HIGH;
            timer_d = HIGH_LD;
          end else begin
            state_d = LOW;
            timer_d = DWELL_LD;
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      HIGH: begin
        if (timer_q == '0) begin
          state_d = LOW;
          timer_d = LOW_LD;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      LOW: begin
        if (timer_q == '0) begin
          if (count_q <= 8'd1) begin
            count_d    = 8'd0;
            state_d    = IDLE;
            seg_done_d = 1'b1;
          end else begin
            count_d = count_q - 8'd1;
            state_d = HIGH;
            timer_d = HIGH_LD;
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      mask_q     <= 4'd0;
      dir_q      <= 4'd0;
      count_q    <= 8'd0;
      seg_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      mask_q     <= mask_d;
      dir_q      <= dir_d;
      count_q    <= count_d;
      seg_done_q <= seg_done_d;
    end
  end

  assign step_out     = (state_q == HIGH) ? mask_q : 4'd0;
  assign dir_out      = dir_q;
  assign busy         = (state_q != IDLE);
  assign segment_done = seg_done_q;

`ifdef STEP_GEN_UNDERRUN_COUNT_EN
  logic [7:0] underrun_q, underrun_d;

  // Segment finished while motion was wanted but no record was waiting.
  always_comb begin
    underrun_d = underrun_q;
    if (seg_done_q && enable && fifo_empty && (underrun_q != 8'hFF))
      underrun_d = underrun_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) underrun_q <= 8'd0;
    else       underrun_q <= underrun_d;
  end

  assign underrun_count = underrun_q;
`endif

endmodule

// File: tb/tb_step_pulse_generator.sv
// Self-checking bench for step_pulse_generator: directed segments plus randomized records against a timeline model.
module tb_step_pulse_generator;
  localparam int SP   = 10;
  localparam int PW   = 3;
  localparam int DS   = 2;
  localparam int LOGN = 16384;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        fifo_empty = 1'b1;
  logic [15:0] fifo_data = 16'h0;
  logic        fifo_read_en, busy, segment_done;
  logic [3:0]  step_out, dir_out;
`ifdef STEP_GEN_UNDERRUN_COUNT_EN
  logic [7:0]  underrun_count;
`endif

  step_pulse_generator #(.STEP_PERIOD(SP), .PULSE_WIDTH(PW), .DIR_SETUP(DS)) dut (
    .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_read_en(fifo_read_en), .step_out(step_out),
    .dir_out(dir_out), .busy(busy), .segment_done(segment_done)
`ifdef STEP_GEN_UNDERRUN_COUNT_EN
    , .underrun_count(underrun_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic nxt_reset = 1'b1;
  logic nxt_enable = 1'b1;
  logic pop_pend = 1'b0;
  logic [15:0] q[$];
  int reads[$];
  logic [3:0] lg_step[LOGN];
  logic [3:0] lg_dir[LOGN];
  logic       lg_busy[LOGN];
  logic       lg_done[LOGN];

  // Model: one segment described by its read cycle and record fields.
  bit have = 0;
  int seg_t = 0, seg_end = 0, r_mask = 0, r_dir = 0, r_cnt = 0, last_dir = 0, um = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [3:0] ls(input int i);
    return (i >= 0 && i < LOGN) ? lg_step[i] : 4'hx;
  endfunction
  function automatic logic [3:0] ld(input int i);
    return (i >= 0 && i < LOGN) ? lg_dir[i] : 4'hx;
  endfunction
  function automatic logic lb(input int i);
    return (i >= 0 && i < LOGN) ? lg_busy[i] : 1'bx;
  endfunction
  function automatic logic lsd(input int i);
    return (i >= 0 && i < LOGN) ? lg_done[i] : 1'bx;
  endfunction

  task automatic cycle();
    int off;
    logic exp_read, exp_done, exp_busy;
    logic [3:0] exp_step;
    @(posedge clk);
    #1;
    reset  = nxt_reset;
    enable = nxt_enable;
    if (pop_pend && q.size() > 0) fifo_data = q.pop_front();
    pop_pend   = 1'b0;
    fifo_empty = (q.size() == 0);
    @(negedge clk);
    if (have && cyc == seg_t + 2) last_dir = r_dir;
    exp_read = !reset && enable && !fifo_empty && (!have || cyc >= seg_end);
    exp_done = have && (cyc == seg_end);
    exp_busy = have && (cyc > seg_t) && (cyc < seg_end);
    off      = cyc - (seg_t + 2 + DS);
    exp_step = (have && off >= 0 && off < r_cnt * SP && (off % SP) < PW) ? 4'(r_mask) : 4'd0;
    if (cyc >= 1) begin
      chk("read_en", 16'(fifo_read_en), 16'(exp_read));
      chk("step_out", 16'(step_out), 16'(exp_step));
      chk("dir_out", 16'(dir_out), 16'(last_dir));
      chk("busy", 16'(busy), 16'(exp_busy));
      chk("segment_done", 16'(segment_done), 16'(exp_done));
`ifdef STEP_GEN_UNDERRUN_COUNT_EN
      chk("underrun_count", 16'(underrun_count), 16'(um));
`endif
    end
    if (cyc < LOGN) begin
      lg_step[cyc] = step_out;
      lg_dir[cyc]  = dir_out;
      lg_busy[cyc] = busy;
      lg_done[cyc] = segment_done;
    end
    if (reset) begin
      have = 0;
      last_dir = 0;
      um = 0;
    end else begin
      if (exp_done && enable && fifo_empty && um < 255) um++;
      if (exp_read) begin
        have    = 1;
        seg_t   = cyc;
        r_mask  = int'(q[0][3:0]);
        r_dir   = int'(q[0][7:4]);
        r_cnt   = int'(q[0][15:8]);
        seg_end = cyc + 2 + DS + ((r_cnt > 0) ? r_cnt : 1) * SP;
      end
    end
    if (fifo_read_en === 1'b1) begin
      pop_pend = 1'b1;
      reads.push_back(cyc);
      if (q.size() == 0) chk("read_on_empty", 16'd1, 16'd0);
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int rb, t, t2, e1;
    logic [3:0] any_step;

    // Reset and single record 0x0351.
    run(3);
    chk("reset_busy", 16'(lb(1)), 16'd0);
    chk("reset_step", 16'(ls(1)), 16'd0);
    chk("reset_dir", 16'(ld(1)), 16'd0);
    chk("reset_done", 16'(lsd(1)), 16'd0);
    nxt_reset = 1'b0;
    rb = reads.size();
    q.push_back(16'h0351);
    run(40);
    chk("A_reads", 16'(reads.size() - rb), 16'd1);
    if (reads.size() > rb) begin
      t = reads[rb];
      chk("A_dir_before", 16'(ld(t + 1)), 16'h0);
      chk("A_dir_t2", 16'(ld(t + 2)), 16'h5);
      chk("A_step_t3", 16'(ls(t + 3)), 16'h0);
      chk("A_step_t4", 16'(ls(t + 4)), 16'h1);
      chk("A_step_t6", 16'(ls(t + 6)), 16'h1);
      chk("A_step_t7", 16'(ls(t + 7)), 16'h0);
      chk("A_step_t14", 16'(ls(t + 14)), 16'h1);
      chk("A_step_t26", 16'(ls(t + 26)), 16'h1);
      chk("A_step_t27", 16'(ls(t + 27)), 16'h0);
      chk("A_busy_t33", 16'(lb(t + 33)), 16'd1);
      chk("A_busy_t34", 16'(lb(t + 34)), 16'd0);
      chk("A_done_t34", 16'(lsd(t + 34)), 16'd1);
    end

    // Back-to-back records.
    rb = reads.size();
    q.push_back(16'h01F3);
    q.push_back(16'h010C);
    run(45);
    chk("B_reads", 16'(reads.size() - rb), 16'd2);
    if (reads.size() >= rb + 2) begin
      t  = reads[rb];
      t2 = reads[rb + 1];
      chk("B_second_read", 16'(t2 - t), 16'd14);
      chk("B_done_at_read", 16'(lsd(t + 14)), 16'd1);
      chk("B_step_t4", 16'(ls(t + 4)), 16'h3);
      chk("B_dir_t15", 16'(ld(t + 15)), 16'hF);
      chk("B_dir_t16", 16'(ld(t + 16)), 16'h0);
      chk("B_step_t18", 16'(ls(t + 18)), 16'hC);
      chk("B_step_t20", 16'(ls(t + 20)), 16'hC);
    end

    // Dwell record, count 0.
    rb = reads.size();
    q.push_back(16'h0051);
    run(20);
    if (reads.size() > rb) begin
      t = reads[rb];
      any_step = 4'd0;
      for (int k = 0; k <= 14; k++) any_step = any_step | ls(t + k);
      chk("C_no_steps", 16'(any_step), 16'd0);
      chk("C_dir", 16'(ld(t + 2)), 16'h5);
      chk("C_done_t14", 16'(lsd(t + 14)), 16'd1);
    end else begin
      chk("C_reads", 16'(reads.size() - rb), 16'd1);
    end

    // Reset in the middle of a step pulse.
    rb = reads.size();
    q.push_back(16'h0351);
    for (int i = 0; i < 10 && reads.size() == rb; i++) cycle();
    chk("D_read", 16'(reads.size() - rb), 16'd1);
    t = (reads.size() > rb) ? reads[rb] : cyc;
    for (int i = 0; i < 20 && (cyc - 1) < t + 4; i++) cycle();
    nxt_reset = 1'b1;
    q.push_back(16'h0351);
    run(5);
    chk("D_no_read_in_reset", 16'(reads.size() - rb), 16'd1);
    chk("D_step_t5", 16'(ls(t + 5)), 16'h1);
    chk("D_dir_t5", 16'(ld(t + 5)), 16'h5);
    chk("D_step_t6", 16'(ls(t + 6)), 16'h0);
    chk("D_busy_t6", 16'(lb(t + 6)), 16'd0);
    chk("D_dir_t6", 16'(ld(t + 6)), 16'h0);
    nxt_reset = 1'b0;
    run(40);

    // Enable low blocks fetches.
    nxt_enable = 1'b0;
    rb = reads.size();
    q.push_back(16'h0151);
    run(50);
    chk("E_no_read", 16'(reads.size() - rb), 16'd0);
    nxt_enable = 1'b1;
    e1 = cyc;
    run(30);
    chk("E_read_count", 16'(reads.size() - rb), 16'd1);
    if (reads.size() > rb) chk("E_read_cycle", 16'(reads[rb] - e1), 16'd0);

    // Randomized records, enable and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      if (q.size() < 3 && $urandom_range(0, 7) == 0)
        q.push_back({8'($urandom_range(0, 3)), 8'($urandom)});
      nxt_enable = ($urandom_range(0, 15) != 0);
      nxt_reset  = ($urandom_range(0, 399) == 0);
      cycle();
    end
    nxt_enable = 1'b1;
    nxt_reset  = 1'b0;
    run(160);

`ifdef STEP_GEN_UNDERRUN_COUNT_EN
    nxt_reset = 1'b1;
    run(2);
    nxt_reset = 1'b0;
    q.push_back(16'h0000);
    run(18);
    chk("U_one", 16'(underrun_count), 16'd1);
    nxt_reset = 1'b1;
    run(2);
    nxt_reset = 1'b0;
    q.push_back(16'h0100);
    run(1);
    nxt_enable = 1'b0;
    run(30);
    chk("U_enable_low", 16'(underrun_count), 16'd0);
    nxt_enable = 1'b1;
    nxt_reset = 1'b1;
    run(2);
    nxt_reset = 1'b0;
    for (int i = 0; i < 300; i++) begin
      q.push_back(16'h0000);
      run(16);
    end
    chk("U_saturate", 16'(underrun_count), 16'd255);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
